// File: rtl/data_sram_resp.sv
// Single-port word SRAM with byte strobes and a fixed-latency, in-order response queue.
// Requests are accepted while fewer than DEPTH are outstanding; each yields one data_ok pulse.
module data_sram_resp #(
  parameter int ADDR_W     = 10,
  parameter int RESP_DELAY = 2,
  parameter int DEPTH      = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW       = $clog2(DEPTH + 1);
  localparam logic [2:0]      CD_INIT  = 3'(RESP_DELAY - 1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(DEPTH);
  localparam logic [PW-1:0]   PTR_LAST = PW'(DEPTH - 1);

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic [31:0]       ent_data [DEPTH];
  logic [DEPTH-1:0]  ent_valid_q, ent_valid_d;
  logic [DEPTH-1:0]  ent_wr_q, ent_wr_d;
  logic [2:0]        ent_cd_q [DEPTH];
  logic [2:0]        ent_cd_d [DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d, sel;
  logic [CW-1:0]     count_q, count_d;
  logic              data_ok_q, data_ok_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] idx;
  logic              accept, retire;
  logic              unused_addr_bits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign idx              = addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};
  assign addr_ok          = (count_q < CNT_MAX);
  // Gating with resetn keeps the unreset memory from taking writes while held in reset.
  assign accept           = req & addr_ok & resetn;
  assign retire           = data_ok_q;
  // The head retires at this edge, so the following entry is the one that may respond next.
  assign sel              = retire ? ptr_inc(head_q) : head_q;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    ent_valid_d = ent_valid_q;
    ent_wr_d    = ent_wr_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      ent_cd_d[i] = (ent_cd_q[i] != 3'd0) ? ent_cd_q[i] - 3'd1 : 3'd0;
    end
    if (retire) begin
      ent_valid_d[head_q] = 1'b0;
      head_d              = ptr_inc(head_q);
    end
    if (accept) begin
      ent_valid_d[tail_q] = 1'b1;
      ent_wr_d[tail_q]    = wr;
      ent_cd_d[tail_q]    = CD_INIT;
      tail_d              = ptr_inc(tail_q);
    end
    case ({accept, retire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    data_ok_d = ent_valid_q[sel] && (ent_cd_q[sel] == 3'd0);
    rdata_d   = (data_ok_d && !ent_wr_q[sel]) ? ent_data[sel] : 32'h0;
  end

  // NOTE: the memory and queued data carry no reset; valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (wr) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        ent_data[tail_q] <= mem[idx];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ent_valid_q <= '0;
      ent_wr_q    <= '0;
      for (int i = 0; i < DEPTH; i++) ent_cd_q[i] <= 3'd0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      data_ok_q   <= 1'b0;
      rdata_q     <= 32'h0;
    end else begin
      ent_valid_q <= ent_valid_d;
      ent_wr_q    <= ent_wr_d;
      for (int i = 0; i < DEPTH; i++) ent_cd_q[i] <= ent_cd_d[i];
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      data_ok_q   <= data_ok_d;
      rdata_q     <= rdata_d;
    end
  end

  assign data_ok = data_ok_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: two configurations driven with the same stimulus and checked
// every cycle against a transaction-level model (memory array plus ordered response schedule).
module tb_data_sram_resp;

  logic        clk = 1'b0;
  logic        resetn, req, wr;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        aok_a, dok_a, aok_b, dok_b;
  logic [31:0] rd_a, rd_b;

  always #5 clk = ~clk;

  data_sram_resp #(.ADDR_W(10), .RESP_DELAY(2), .DEPTH(4)) dut_a (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .wstrb(wstrb), .addr(addr),
    .wdata(wdata), .addr_ok(aok_a), .data_ok(dok_a), .rdata(rd_a));

  data_sram_resp #(.ADDR_W(10), .RESP_DELAY(7), .DEPTH(2)) dut_b (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .wstrb(wstrb), .addr(addr),
    .wdata(wdata), .addr_ok(aok_b), .data_ok(dok_b), .rdata(rd_b));

  typedef struct {
    int          m;
    int          t;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem_m [2][1024];
  int          dly [2] = '{2, 7};
  int          dep [2] = '{4, 2};
  int          occ [2];
  int          last_t [2];
  int          e;
  int          errors = 0;
  int          checks = 0;
  int          dok_count_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] mk_addr(input int w);
    logic [31:0] r;
    r = $urandom;
    return {r[31:12], 10'(w), r[1:0]};
  endfunction

  // Compare both DUTs against the schedule after edge e; responses due at e are consumed.
  task automatic observe();
    for (int m = 0; m < 2; m++) begin
      logic        ao, dk, exp_dk;
      logic [31:0] rd, exp_rd;
      int          n, first;
      ao = (m == 0) ? aok_a : aok_b;
      dk = (m == 0) ? dok_a : dok_b;
      rd = (m == 0) ? rd_a  : rd_b;
      n = 0;
      first = -1;
      for (int i = 0; i < q.size(); i++) begin
        if (q[i].m == m) begin
          if (first < 0) first = i;
          n++;
        end
      end
      occ[m] = n;
      exp_dk = (first >= 0) && (q[first].t == e);
      exp_rd = exp_dk ? q[first].data : 32'h0;
      check($sformatf("m%0d_addr_ok_e%0d", m, e), 32'(ao), 32'(n < dep[m]));
      check($sformatf("m%0d_data_ok_e%0d", m, e), 32'(dk), 32'(exp_dk));
      check($sformatf("m%0d_rdata_e%0d", m, e), rd, exp_rd);
      if (exp_dk) q.delete(first);
      if (m == 0 && dk === 1'b1) dok_count_a++;
    end
  endtask

  task automatic cycle(input logic r, input logic w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    bit acc [2];
    req = r; wr = w; wstrb = s; addr = a; wdata = d;
    for (int m = 0; m < 2; m++) acc[m] = r && (occ[m] < dep[m]);
    @(posedge clk);
    e++;
    for (int m = 0; m < 2; m++) begin
      if (acc[m]) begin
        int          idx, t;
        logic [31:0] data;
        idx  = int'(a[11:2]);
        data = 32'h0;
        if (w) begin
          for (int b = 0; b < 4; b++)
            if (s[b]) mem_m[m][idx][8*b +: 8] = d[8*b +: 8];
        end else begin
          data = mem_m[m][idx];
        end
        t = (e + dly[m] > last_t[m] + 1) ? e + dly[m] : last_t[m] + 1;
        last_t[m] = t;
        q.push_back('{m, t, data});
      end
    end
    #1;
    observe();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_data_ok"}, 32'(dok_a), 32'h0);
    check({tag, "_a_rdata"},   rd_a,       32'h0);
    check({tag, "_a_addr_ok"}, 32'(aok_a), 32'h1);
    check({tag, "_b_data_ok"}, 32'(dok_b), 32'h0);
    check({tag, "_b_rdata"},   rd_b,       32'h0);
    check({tag, "_b_addr_ok"}, 32'(aok_b), 32'h1);
  endtask

  initial begin
    resetn = 1'b0; req = 1'b0; wr = 1'b0; wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;
    e = 0; occ = '{0, 0}; last_t = '{0, 0};
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    resetn = 1'b1;

    // Write then read 0x40; write response first (rdata 0), then the read data.
    cycle(1'b1, 1'b1, 4'hF, 32'h40, 32'h11223344);
    cycle(1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
    idle(1);
    check("wr_resp_data_ok", 32'(dok_a), 32'h1);
    check("wr_resp_rdata", rd_a, 32'h0);
    idle(1);
    check("rd_resp_data_ok", 32'(dok_a), 32'h1);
    check("rd_resp_rdata", rd_a, 32'h11223344);

    // Partial-strobe merge over the previous word.
    cycle(1'b1, 1'b1, 4'b0101, 32'h40, 32'hAABBCCDD);
    cycle(1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
    idle(2);
    check("strobe_merge_rdata", rd_a, 32'h11BB33DD);
    idle(10);

    // Give every word in the test window a known value in both instances.
    for (int w = 0; w < 32; w++) begin
      cycle(1'b1, 1'b1, 4'hF, mk_addr(w), $urandom);
      idle(8);
    end

    // Ten back-to-back reads: full throughput on the shallow-latency instance.
    dok_count_a = 0;
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 4'h0, mk_addr(i + 3), 32'h0);
    idle(6);
    check("burst_pulse_count", 32'(dok_count_a), 32'd10);
    idle(12);

    // Held request: the long-latency instance fills at two and stalls until retirement.
    for (int i = 0; i < 14; i++) cycle(1'b1, 1'b0, 4'h0, mk_addr(i), 32'h0);
    idle(16);

    // Random mix with random gaps.
    for (int i = 0; i < 400; i++) begin
      logic r, w;
      r = ($urandom_range(0, 99) < 60);
      w = ($urandom_range(0, 1) == 1);
      cycle(r, w, 4'($urandom), mk_addr($urandom_range(0, 31)), $urandom);
    end
    idle(16);

    // Asynchronous reset with three reads outstanding.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 4'h0, mk_addr(i), 32'h0);
    check("pre_reset_data_ok", 32'(dok_a), 32'h1);
    req = 1'b0;
    #2;
    resetn = 1'b0;
    q.delete();
    occ = '{0, 0};
    last_t = '{0, 0};
    #1;
    check_reset_outputs("async");
    repeat (2) begin
      @(posedge clk);
      e++;
    end
    #1;
    resetn = 1'b1;
    dok_count_a = 0;
    idle(10);
    check("post_reset_no_resp", 32'(dok_count_a), 32'h0);

    // Memory survives reset: read back words written before it.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 4'h0, mk_addr(i * 5), 32'h0);
    idle(16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
